// File: rtl/score_display_if.sv
// Bundles the scoring, key, pixel-position and colour/score signals of score_display.
// Master drives the inputs of the score display; slave is the score display itself.
interface score_display_if;
  logic       i_p1_scored;
  logic       i_p2_scored;
  logic [7:0] i_key_byte;
  logic       i_key_valid;
  logic [9:0] i_display_x_pos;
  logic [9:0] i_display_y_pos;
  logic [2:0] o_red;
  logic [2:0] o_green;
  logic [2:0] o_blue;
  logic [3:0] o_p1_score;
  logic [3:0] o_p2_score;
  logic       o_game_over;
  logic       o_winner;

  modport master (
    output i_p1_scored, i_p2_scored, i_key_byte, i_key_valid,
           i_display_x_pos, i_display_y_pos,
    input  o_red, o_green, o_blue, o_p1_score, o_p2_score, o_game_over, o_winner
  );

  modport slave (
    input  i_p1_scored, i_p2_scored, i_key_byte, i_key_valid,
           i_display_x_pos, i_display_y_pos,
    output o_red, o_green, o_blue, o_p1_score, o_p2_score, o_game_over, o_winner
  );
endinterface

// File: rtl/score_display.sv
// Match scorekeeper: synchronises point inputs, runs PLAYING/GAME_OVER, and draws
// both scores as seven-segment digits with one registered pixel stage.
module score_display #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned P1_DIGIT_X  = 280,
  parameter int unsigned P2_DIGIT_X  = 340,
  parameter int unsigned DIGIT_Y     = 20,
  parameter int unsigned SEG_LEN     = 20,
  parameter int unsigned SEG_THICK   = 4,
  parameter int unsigned RESTART_KEY = 114
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  score_display_if.slave  bus
);
  localparam int unsigned SW = 4;
  localparam int unsigned PW = 11;

  localparam logic [PW-1:0] C_Y   = PW'(DIGIT_Y);
  localparam logic [PW-1:0] C_W   = PW'(SEG_LEN);
  localparam logic [PW-1:0] C_T   = PW'(SEG_THICK);
  localparam logic [PW-1:0] C_TH  = PW'(SEG_THICK / 2);
  localparam logic [PW-1:0] C_X1  = PW'(P1_DIGIT_X);
  localparam logic [PW-1:0] C_X2  = PW'(P2_DIGIT_X);
  localparam logic [SW-1:0] C_WIN = SW'(WIN_SCORE);

  typedef enum logic {ST_PLAYING = 1'b0, ST_GAME_OVER = 1'b1} state_t;

  // Segment mask ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_mask(input logic [SW-1:0] digit);
    case (digit)
      4'd0:    seg_mask = 7'b0111111;
      4'd1:    seg_mask = 7'b0000110;
      4'd2:    seg_mask = 7'b1011011;
      4'd3:    seg_mask = 7'b1001111;
      4'd4:    seg_mask = 7'b1100110;
      4'd5:    seg_mask = 7'b1101101;
      4'd6:    seg_mask = 7'b1111101;
      4'd7:    seg_mask = 7'b0000111;
      4'd8:    seg_mask = 7'b1111111;
      4'd9:    seg_mask = 7'b1101111;
      default: seg_mask = 7'b0000000;
    endcase
  endfunction

  function automatic logic seg_lit(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                   input logic [PW-1:0] xl, input logic [SW-1:0] digit);
    logic [6:0]    m;
    logic [PW-1:0] xr, xrt, xlt, yt, ym, yb, ybt, ygt, ygb;
    logic          x_full, x_rt, x_lf, y_top, y_bot;
    m      = seg_mask(digit);
    xr     = xl + C_W;
    xrt    = xr - C_T;
    xlt    = xl + C_T;
    yt     = C_Y + C_T;
    ym     = C_Y + C_W;
    yb     = ym + C_W;
    ybt    = yb - C_T;
    ygt    = ym - C_TH;
    ygb    = ym + C_TH;
    x_full = (x >= xl)  && (x < xr);
    x_rt   = (x >= xrt) && (x < xr);
    x_lf   = (x >= xl)  && (x < xlt);
    y_top  = (y >= C_Y) && (y < ym);
    y_bot  = (y >= ym)  && (y < yb);
    seg_lit = (m[0] && x_full && (y >= C_Y) && (y < yt))
            | (m[1] && x_rt && y_top)
            | (m[2] && x_rt && y_bot)
            | (m[3] && x_full && (y >= ybt) && (y < yb))
            | (m[4] && x_lf && y_bot)
            | (m[5] && x_lf && y_top)
            | (m[6] && x_full && (y >= ygt) && (y < ygb));
  endfunction

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_p1_score, r_p2_score, w_p1_nxt, w_p2_nxt;
  logic          r_winner, w_winner_nxt;
  logic [1:0]    r_p1_sync, r_p2_sync;
  logic          r_p1_prev, r_p2_prev;
  logic [2:0]    r_red, r_green, r_blue;
  logic          w_p1_pulse, w_p2_pulse, w_restart;
  logic          w_p1_lit, w_p2_lit, w_p1_green, w_p2_green, w_any_white;
  logic [PW-1:0] w_x, w_y;

  // 2-flop synchronisers followed by rising-edge detectors
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_p1_sync <= 2'b00;
      r_p2_sync <= 2'b00;
      r_p1_prev <= 1'b0;
      r_p2_prev <= 1'b0;
    end else begin
      r_p1_sync <= {r_p1_sync[0], bus.i_p1_scored};
      r_p2_sync <= {r_p2_sync[0], bus.i_p2_scored};
      r_p1_prev <= r_p1_sync[1];
      r_p2_prev <= r_p2_sync[1];
    end
  end

  assign w_p1_pulse = r_p1_sync[1] & ~r_p1_prev;
  assign w_p2_pulse = r_p2_sync[1] & ~r_p2_prev;
  assign w_restart  = bus.i_key_valid && (bus.i_key_byte == 8'(RESTART_KEY));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state    <= ST_PLAYING;
      r_p1_score <= '0;
      r_p2_score <= '0;
      r_winner   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_p1_score <= w_p1_nxt;
      r_p2_score <= w_p2_nxt;
      r_winner   <= w_winner_nxt;
    end
  end

  // Restart has priority over points; player 1 wins a simultaneous finish
  always_comb begin
    w_state_nxt  = r_state;
    w_p1_nxt     = r_p1_score;
    w_p2_nxt     = r_p2_score;
    w_winner_nxt = r_winner;
    if (w_restart) begin
      w_state_nxt  = ST_PLAYING;
      w_p1_nxt     = '0;
      w_p2_nxt     = '0;
      w_winner_nxt = 1'b0;
    end else if (r_state == ST_PLAYING) begin
      if (w_p1_pulse) w_p1_nxt = r_p1_score + SW'(1);
      if (w_p2_pulse) w_p2_nxt = r_p2_score + SW'(1);
      if (w_p1_pulse && (w_p1_nxt == C_WIN)) begin
        w_state_nxt  = ST_GAME_OVER;
        w_winner_nxt = 1'b0;
      end else if (w_p2_pulse && (w_p2_nxt == C_WIN)) begin
        w_state_nxt  = ST_GAME_OVER;
        w_winner_nxt = 1'b1;
      end
    end
  end

  assign w_x         = PW'(bus.i_display_x_pos);
  assign w_y         = PW'(bus.i_display_y_pos);
  assign w_p1_lit    = seg_lit(w_x, w_y, C_X1, r_p1_score);
  assign w_p2_lit    = seg_lit(w_x, w_y, C_X2, r_p2_score);
  assign w_p1_green  = (r_state == ST_GAME_OVER) && !r_winner;
  assign w_p2_green  = (r_state == ST_GAME_OVER) &&  r_winner;
  assign w_any_white = (w_p1_lit && !w_p1_green) || (w_p2_lit && !w_p2_green);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_red   <= {3{w_any_white}};
      r_green <= {3{w_p1_lit || w_p2_lit}};
      r_blue  <= {3{w_any_white}};
    end
  end

  assign bus.o_red       = r_red;
  assign bus.o_green     = r_green;
  assign bus.o_blue      = r_blue;
  assign bus.o_p1_score  = r_p1_score;
  assign bus.o_p2_score  = r_p2_score;
  assign bus.o_game_over = (r_state == ST_GAME_OVER);
  assign bus.o_winner    = r_winner;
endmodule

// File: tb/tb_score_display.sv
// Directed + randomized bench for score_display against a cycle-level match model
// built from point latency, restart priority and rectangle-based digit geometry.
module tb_score_display;
  localparam int WIN = 9;
  localparam int P1X = 280;
  localparam int P2X = 340;
  localparam int DY  = 20;
  localparam int W   = 20;
  localparam int T   = 4;
  localparam int KEY = 114;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  score_display_if bus();

  score_display #(
    .WIN_SCORE(WIN), .P1_DIGIT_X(P1X), .P2_DIGIT_X(P2X), .DIGIT_Y(DY),
    .SEG_LEN(W), .SEG_THICK(T), .RESTART_KEY(KEY)
  ) dut (
    .i_CLK(clk),
    .i_RST_N(rst_n),
    .bus(bus)
  );

  int vecs = 0;
  int miscompares = 0;

  // Match model: scores, match-over flag, winner, and point pipeline (rise seen -> +2 edges)
  int m_p1, m_p2;
  bit m_over, m_win;
  bit prev1, prev2, a1_1, a2_1, a1_2, a2_2;

  string SEGS[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic bit in_r(int v, int lo, int hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic bit lit(int x, int y, int X, int d);
    bit r = 1'b0;
    string s = SEGS[d];
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": r |= in_r(x, X, X+W)     && in_r(y, DY, DY+T);
        "b": r |= in_r(x, X+W-T, X+W) && in_r(y, DY, DY+W);
        "c": r |= in_r(x, X+W-T, X+W) && in_r(y, DY+W, DY+2*W);
        "d": r |= in_r(x, X, X+W)     && in_r(y, DY+2*W-T, DY+2*W);
        "e": r |= in_r(x, X, X+T)     && in_r(y, DY+W, DY+2*W);
        "f": r |= in_r(x, X, X+T)     && in_r(y, DY, DY+W);
        "g": r |= in_r(x, X, X+W)     && in_r(y, DY+W-T/2, DY+W+T/2);
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_over = 0; m_win = 0;
    prev1 = 0; prev2 = 0; a1_1 = 0; a2_1 = 0; a1_2 = 0; a2_2 = 0;
  endtask

  // One clock edge: predict pixel colour from pre-edge state, advance model, compare
  task automatic tick();
    int er, eg;
    bit l1, l2, rs, lit1, lit2, ap1, ap2;
    lit1 = lit(int'(bus.i_display_x_pos), int'(bus.i_display_y_pos), P1X, m_p1);
    lit2 = lit(int'(bus.i_display_x_pos), int'(bus.i_display_y_pos), P2X, m_p2);
    eg = (lit1 || lit2) ? 7 : 0;
    er = ((lit1 && !(m_over && !m_win)) || (lit2 && !(m_over && m_win))) ? 7 : 0;
    l1 = bus.i_p1_scored;
    l2 = bus.i_p2_scored;
    rs = bus.i_key_valid && (int'(bus.i_key_byte) == KEY);
    @(posedge clk);
    #1;
    ap1 = a2_1; a2_1 = a1_1; a1_1 = l1 && !prev1; prev1 = l1;
    ap2 = a2_2; a2_2 = a1_2; a1_2 = l2 && !prev2; prev2 = l2;
    if (rs) begin
      m_p1 = 0; m_p2 = 0; m_over = 0; m_win = 0;
    end else if (!m_over) begin
      if (ap1) m_p1++;
      if (ap2) m_p2++;
      if (ap1 && m_p1 == WIN) begin m_over = 1; m_win = 0; end
      else if (ap2 && m_p2 == WIN) begin m_over = 1; m_win = 1; end
    end
    chk("p1_score", 32'(bus.o_p1_score), 32'(m_p1));
    chk("p2_score", 32'(bus.o_p2_score), 32'(m_p2));
    chk("game_over", 32'(bus.o_game_over), 32'(m_over));
    chk("winner", 32'(bus.o_winner), 32'(m_win));
    chk("red", 32'(bus.o_red), 32'(er));
    chk("green", 32'(bus.o_green), 32'(eg));
    chk("blue", 32'(bus.o_blue), 32'(er));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(bit p1, bit p2);
    bus.i_p1_scored = p1;
    bus.i_p2_scored = p2;
    ticks(3);
    bus.i_p1_scored = 1'b0;
    bus.i_p2_scored = 1'b0;
    ticks(3);
  endtask

  task automatic restart();
    bus.i_key_byte  = 8'(KEY);
    bus.i_key_valid = 1'b1;
    tick();
    bus.i_key_valid = 1'b0;
    bus.i_key_byte  = 8'h00;
  endtask

  task automatic rand_pix();
    bus.i_display_x_pos = 10'($urandom_range(272, 368));
    bus.i_display_y_pos = 10'($urandom_range(14, 66));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_p1"}, 32'(bus.o_p1_score), 32'd0);
    chk({tag, "_p2"}, 32'(bus.o_p2_score), 32'd0);
    chk({tag, "_over"}, 32'(bus.o_game_over), 32'd0);
    chk({tag, "_win"}, 32'(bus.o_winner), 32'd0);
    chk({tag, "_rgb"}, 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_p1_scored = 1'b0;
    bus.i_p2_scored = 1'b0;
    bus.i_key_byte = 8'h00;
    bus.i_key_valid = 1'b0;
    bus.i_display_x_pos = 10'd0;
    bus.i_display_y_pos = 10'd0;
    model_reset();
    #23;
    chk_zero("reset");
    rst_n = 1'b1;

    // Idle scan over the digit area
    for (int i = 0; i < 100; i++) begin
      rand_pix();
      tick();
    end

    // Long p1 level gives exactly one point
    bus.i_p1_scored = 1'b1;
    ticks(50);
    bus.i_p1_scored = 1'b0;
    ticks(5);

    // Nine p2 points end the match; further points are ignored
    for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    ticks(3);

    // Restart byte without strobe, then with strobe
    bus.i_key_byte = 8'(KEY);
    ticks(2);
    bus.i_key_byte = 8'h00;
    restart();
    ticks(2);

    // Restart coinciding with the edge where a point would land
    bus.i_p1_scored = 1'b1;
    tick();
    tick();
    bus.i_key_byte  = 8'(KEY);
    bus.i_key_valid = 1'b1;
    tick();
    bus.i_key_valid = 1'b0;
    bus.i_p1_scored = 1'b0;
    ticks(4);

    // 8/8 then a simultaneous finish: player 1 wins
    restart();
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    ticks(2);

    // Pixel checks on segment b of player-1 digit, white then green after win
    restart();
    pulse(1'b1, 1'b0);
    bus.i_display_x_pos = 10'(P1X + W - 1);
    bus.i_display_y_pos = 10'(DY + 5);
    ticks(3);
    bus.i_display_x_pos = 10'(P1X);
    bus.i_display_y_pos = 10'(DY);
    ticks(2);
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
    bus.i_display_x_pos = 10'(P1X + W - 1);
    bus.i_display_y_pos = 10'(DY + 5);
    ticks(3);
    for (int i = 0; i < 40; i++) begin
      rand_pix();
      tick();
    end

    // Randomised play with occasional restarts and decoy key bytes
    restart();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) bus.i_p1_scored = ~bus.i_p1_scored;
      if ($urandom_range(0, 3) == 0) bus.i_p2_scored = ~bus.i_p2_scored;
      case ($urandom_range(0, 59))
        0:       begin bus.i_key_byte = 8'(KEY); bus.i_key_valid = 1'b1; end
        1:       begin bus.i_key_byte = 8'(KEY); bus.i_key_valid = 1'b0; end
        2, 3:    begin bus.i_key_byte = 8'($urandom_range(0, 113)); bus.i_key_valid = 1'b1; end
        default: begin bus.i_key_byte = 8'h00; bus.i_key_valid = 1'b0; end
      endcase
      rand_pix();
      tick();
    end
    bus.i_key_valid = 1'b0;

    // Asynchronous reset mid-match
    bus.i_p1_scored = 1'b0;
    bus.i_p2_scored = 1'b0;
    restart();
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
    bus.i_display_x_pos = 10'(P1X + W - 1);
    bus.i_display_y_pos = 10'(DY + 5);
    ticks(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ticks(5);

    // Input already high at reset release counts as one point
    rst_n = 1'b0;
    bus.i_p2_scored = 1'b1;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ticks(8);
    bus.i_p2_scored = 1'b0;
    ticks(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
